// File: rtl/vga_frame_arbiter.sv
// 40x30 one-bit tile framebuffer shared by two write requesters.
// Writes and row-by-row clears are applied only while vertical blanking is active.
module vga_frame_arbiter (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [10:0]  v_position,
  input  logic         req0,
  input  logic [10:0]  addr0,
  input  logic         wdata0,
  output logic         gnt0,
  input  logic         req1,
  input  logic [10:0]  addr1,
  input  logic         wdata1,
  output logic         gnt1,
  input  logic         clear_req,
  output logic         clear_busy,
  output logic         err_addr,
  output logic         blank_active,
  output logic [1199:0] frame_data
);

  localparam int unsigned COLS      = 40;
  localparam int unsigned TILES     = 1200;
  localparam logic [10:0] TILES_W   = 11'd1200;
  localparam logic [10:0] COLS_W    = 11'd40;
  localparam logic [4:0]  LAST_ROW  = 5'd29;
  localparam logic [10:0] V_DISPLAY = 11'd480;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [TILES-1:0] frame_q, frame_d;
  logic [4:0]      row_cnt_q, row_cnt_d;
  logic            clear_busy_q, clear_busy_d;
  logic            blank_active_q, blank_active_d;
  logic            last_served_q, last_served_d;
  logic            gnt0_q, gnt0_d;
  logic            gnt1_q, gnt1_d;
  logic            err_addr_q, err_addr_d;

  logic            elig0, elig1;
  logic            sel_valid, sel_id, sel_wdata;
  logic [10:0]     sel_addr;
  logic [10:0]     row_base;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      frame_q        <= '0;
      row_cnt_q      <= '0;
      clear_busy_q   <= 1'b0;
      blank_active_q <= 1'b0;
      last_served_q  <= 1'b1;
      gnt0_q         <= 1'b0;
      gnt1_q         <= 1'b0;
      err_addr_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_q        <= frame_d;
      row_cnt_q      <= row_cnt_d;
      clear_busy_q   <= clear_busy_d;
      blank_active_q <= blank_active_d;
      last_served_q  <= last_served_d;
      gnt0_q         <= gnt0_d;
      gnt1_q         <= gnt1_d;
      err_addr_q     <= err_addr_d;
    end
  end

  // A requester still showing its grant is skipped, so a held request is not served twice.
  always_comb begin
    elig0     = req0 & ~gnt0_q;
    elig1     = req1 & ~gnt1_q;
    sel_valid = elig0 | elig1;
    sel_id    = 1'b0;
    if (elig0 && elig1) begin
      sel_id = ~last_served_q;
    end else if (elig1) begin
      sel_id = 1'b1;
    end
    sel_addr  = sel_id ? addr1 : addr0;
    sel_wdata = sel_id ? wdata1 : wdata0;
    row_base  = 11'(row_cnt_q) * COLS_W;
  end

  always_comb begin
    state_d        = state_q;
    frame_d        = frame_q;
    row_cnt_d      = row_cnt_q;
    clear_busy_d   = clear_busy_q;
    last_served_d  = last_served_q;
    gnt0_d         = 1'b0;
    gnt1_d         = 1'b0;
    err_addr_d     = 1'b0;
    blank_active_d = (v_position >= V_DISPLAY);

    if (clear_req && !clear_busy_q) begin
      clear_busy_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (blank_active_q) begin
          if (clear_busy_q) begin
            state_d = CLEAR;
          end else if (sel_valid) begin
            if (sel_addr < TILES_W) begin
              frame_d[sel_addr] = sel_wdata;
            end else begin
              err_addr_d = 1'b1;
            end
            gnt0_d        = ~sel_id;
            gnt1_d        = sel_id;
            last_served_d = sel_id;
          end
        end
      end
      CLEAR: begin
        // Outside blanking the clear simply pauses on the current row.
        if (blank_active_q) begin
          frame_d[row_base +: COLS] = '0;
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_d    = '0;
            clear_busy_d = 1'b0;
            state_d      = IDLE;
          end else begin
            row_cnt_d = row_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt0         = gnt0_q;
  assign gnt1         = gnt1_q;
  assign err_addr     = err_addr_q;
  assign clear_busy   = clear_busy_q;
  assign blank_active = blank_active_q;
  assign frame_data   = frame_q;

endmodule

// File: tb/tb_vga_frame_arbiter.sv
// Directed testbench for vga_frame_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_vga_frame_arbiter;

  logic          clk;
  logic          reset_n;
  logic [10:0]   v_position;
  logic          req0, req1;
  logic [10:0]   addr0, addr1;
  logic          wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          clear_req;
  logic          clear_busy;
  logic          err_addr;
  logic          blank_active;
  logic [1199:0] frame_data;

  int checks;
  int errors;

  vga_frame_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .v_position   (v_position),
    .req0         (req0),
    .addr0        (addr0),
    .wdata0       (wdata0),
    .gnt0         (gnt0),
    .req1         (req1),
    .addr1        (addr1),
    .wdata1       (wdata1),
    .gnt1         (gnt1),
    .clear_req    (clear_req),
    .clear_busy   (clear_busy),
    .err_addr     (err_addr),
    .blank_active (blank_active),
    .frame_data   (frame_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; clear_req = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wr0(input logic [10:0] a, input logic d);
    int n;
    req0 = 1'b1; addr0 = a; wdata0 = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!gnt0 && n < 8);
    req0 = 1'b0;
    if (!gnt0) begin
      checks++; errors++;
      $display("FAIL wr0_timeout addr=%0d: gnt0 never seen", a);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; req0 = 1'b1; addr0 = 11'd3; wdata0 = 1'b1; clear_req = 1'b1;
    tick(); tick();
    checks++;
    if (frame_data !== '0) begin errors++; $display("FAIL reset_frame ones=%0d want 0", $countones(frame_data)); end
    checks++;
    if ({gnt0, gnt1, err_addr, clear_busy, blank_active} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs gnt0=%b gnt1=%b err=%b busy=%b blank=%b want all 0", gnt0, gnt1, err_addr, clear_busy, blank_active);
    end
    req0 = 1'b0; clear_req = 1'b0; reset_n = 1'b1;
  endtask

  task automatic test_blank_gating();
    logic seen;
    apply_reset();
    v_position = 11'd100;
    req0 = 1'b1; addr0 = 11'd5; wdata0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt0 || blank_active) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL gating_no_gnt got gnt/blank during display want none"); end
    v_position = 11'd480;
    tick();
    checks++;
    if (blank_active !== 1'b1 || gnt0 !== 1'b0) begin
      errors++; $display("FAIL gating_blank_edge blank=%b gnt0=%b want 1 0", blank_active, gnt0);
    end
    tick();
    checks++;
    if (gnt0 !== 1'b1 || frame_data[5] !== 1'b1) begin
      errors++; $display("FAIL gating_grant gnt0=%b tile5=%b want 1 1", gnt0, frame_data[5]);
    end
    req0 = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rr [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] exp_single [4] = '{2'b01, 2'b00, 2'b01, 2'b00};
    apply_reset();
    v_position = 11'd480;
    req0 = 1'b1; addr0 = 11'd10; wdata0 = 1'b1;
    req1 = 1'b1; addr1 = 11'd20; wdata1 = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({gnt1, gnt0} !== exp_rr[i]) begin
        errors++; $display("FAIL rr_seq[%0d] gnt1gnt0=%b want %b", i, {gnt1, gnt0}, exp_rr[i]);
      end
    end
    checks++;
    if (frame_data[10] !== 1'b1 || frame_data[20] !== 1'b1) begin
      errors++; $display("FAIL rr_data tile10=%b tile20=%b want 1 1", frame_data[10], frame_data[20]);
    end
    req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({gnt1, gnt0} !== exp_single[i]) begin
        errors++; $display("FAIL single_rate[%0d] gnt1gnt0=%b want %b", i, {gnt1, gnt0}, exp_single[i]);
      end
    end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_bad_addr();
    apply_reset();
    v_position = 11'd480;
    req0 = 1'b1; addr0 = 11'd1200; wdata0 = 1'b1;
    tick(); tick();
    checks++;
    if (gnt0 !== 1'b1 || err_addr !== 1'b1 || frame_data !== '0) begin
      errors++; $display("FAIL bad_addr gnt0=%b err=%b ones=%0d want 1 1 0", gnt0, err_addr, $countones(frame_data));
    end
    req0 = 1'b0;
    req1 = 1'b1; addr1 = 11'd1199; wdata1 = 1'b1;
    tick();
    checks++;
    if (gnt1 !== 1'b1 || err_addr !== 1'b0 || frame_data[1199] !== 1'b1 || gnt0 !== 1'b0) begin
      errors++; $display("FAIL last_tile gnt1=%b err=%b tile1199=%b gnt0=%b want 1 0 1 0", gnt1, err_addr, frame_data[1199], gnt0);
    end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_split_clear();
    logic [1199:0] exp_frame;
    logic bad;
    apply_reset();
    v_position = 11'd480;
    tick();
    for (int i = 0; i < 1200; i++) wr0(11'(i), 1'b1);
    checks++;
    if (frame_data !== {1200{1'b1}}) begin errors++; $display("FAIL fill_ones ones=%0d want 1200", $countones(frame_data)); end
    v_position = 11'd0;
    tick(); tick();
    clear_req = 1'b1; req1 = 1'b1; addr1 = 11'd7; wdata1 = 1'b1;
    tick();
    clear_req = 1'b0;
    checks++;
    if (clear_busy !== 1'b1) begin errors++; $display("FAIL clear_busy_set got %b want 1", clear_busy); end
    v_position = 11'd480;
    bad = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (gnt1) bad = 1'b1;
    end
    v_position = 11'd0;
    tick();
    exp_frame = {1200{1'b1}};
    for (int i = 0; i < 400; i++) exp_frame[i] = 1'b0;
    checks++;
    if (frame_data !== exp_frame || clear_busy !== 1'b1) begin
      errors++; $display("FAIL split_first_part ones=%0d busy=%b want 800 1", $countones(frame_data), clear_busy);
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      if (frame_data !== exp_frame || gnt1 || !clear_busy) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL split_pause got change/gnt1 while paused want none"); end
    v_position = 11'd480;
    tick();
    for (int i = 0; i < 19; i++) begin
      tick();
      if (!clear_busy || gnt1) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL split_resume busy dropped or gnt1 early, want busy held"); end
    tick();
    checks++;
    if (clear_busy !== 1'b0 || frame_data !== '0 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL clear_done busy=%b ones=%0d gnt1=%b want 0 0 0", clear_busy, $countones(frame_data), gnt1);
    end
    tick();
    checks++;
    if (gnt1 !== 1'b1 || frame_data[7] !== 1'b1 || $countones(frame_data) != 1) begin
      errors++; $display("FAIL post_clear_grant gnt1=%b tile7=%b ones=%0d want 1 1 1", gnt1, frame_data[7], $countones(frame_data));
    end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_clear();
    wr0(11'd1000, 1'b1);
    v_position = 11'd0;
    tick(); tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    v_position = 11'd480;
    repeat (17) tick();
    checks++;
    if (frame_data[1000] !== 1'b1 || frame_data[7] !== 1'b0 || clear_busy !== 1'b1) begin
      errors++; $display("FAIL mid_clear_state tile1000=%b tile7=%b busy=%b want 1 0 1", frame_data[1000], frame_data[7], clear_busy);
    end
    reset_n = 1'b0;
    req0 = 1'b1; addr0 = 11'd3; wdata0 = 1'b1;
    tick();
    checks++;
    if (frame_data !== '0 || clear_busy !== 1'b0 || gnt0 !== 1'b0) begin
      errors++; $display("FAIL mid_clear_reset ones=%0d busy=%b gnt0=%b want 0 0 0", $countones(frame_data), clear_busy, gnt0);
    end
    reset_n = 1'b1;
    tick(); tick();
    checks++;
    if (gnt0 !== 1'b1 || frame_data[3] !== 1'b1 || clear_busy !== 1'b0) begin
      errors++; $display("FAIL after_reset_grant gnt0=%b tile3=%b busy=%b want 1 1 0", gnt0, frame_data[3], clear_busy);
    end
    req0 = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; v_position = 11'd0;
    req0 = 1'b0; addr0 = '0; wdata0 = 1'b0;
    req1 = 1'b0; addr1 = '0; wdata1 = 1'b0;
    clear_req = 1'b0;
    test_reset();
    test_blank_gating();
    test_round_robin();
    test_bad_addr();
    test_split_clear();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
